// File: rtl/pulse_pkg.sv
// Shared light-pulse definitions: scale codes, scale constants and FSM encoding.
// The delay stage reuses the same scale codes.
package pulse_pkg;

  localparam int          CNT_W       = 17;
  localparam logic [4:0]  MLT_X1      = 5'd1;
  localparam logic [4:0]  MLT_X100    = 5'd2;
  localparam int unsigned SCALE_X100  = 100;
  localparam int unsigned SCALE_X100K = 100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } pulse_state_t;

  // Terminal prescaler count for a scale code; unknown codes select the slowest scale.
  function automatic logic [CNT_W-1:0] tick_period_m1(input logic [4:0] mlt);
    logic [CNT_W-1:0] last;
    case (mlt)
      MLT_X1:   last = '0;
      MLT_X100: last = CNT_W'(SCALE_X100 - 1);
      default:  last = CNT_W'(SCALE_X100K - 1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/pl_tick_gen.sv
// Prescaler for the pulse generator: one-cycle tick every scale cycles while enabled,
// counting from zero after a clear.
import pulse_pkg::*;

module pl_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [4:0] mlt,
  output logic       tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  assign last = tick_period_m1(mlt);
  assign tick = enable && (cnt == last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// Light-pulse generator: on a launch rising edge drives PL_out for pulse_len x scale
// cycles, strobes End_Flg_PL on normal completion, then holds until launch drops.
import pulse_pkg::*;

module pulse_gen (
  input  logic        clk_Pulse,
  input  logic        rst_Pulse,
  input  logic        PL_launch,
  input  logic [16:0] pulse_len,
  input  logic [4:0]  pl_mlt,
  output logic        PL_out,
  output logic        End_Flg_PL,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: PL_launch is a level; a pulse starts only on its sampled 0->1 transition
  // and lowering it mid-pulse aborts the pulse without a completion strobe.

  pulse_state_t     state;
  logic             launch_prev;
  logic [CNT_W-1:0] len_q;
  logic [4:0]       mlt_q;
  logic [CNT_W-1:0] unit_cnt;
  logic [CNT_W-1:0] unit_nxt;
  logic             tick;
  logic             in_pulse;
  logic             launch_edge;

  assign in_pulse    = (state == ST_PULSE);
  assign launch_edge = PL_launch && !launch_prev;
  assign unit_nxt    = unit_cnt + CNT_W'(1);
  assign state_dbg   = state;

  // Clearing on a low launch resets the prescaler in the same edge as an abort.
  pl_tick_gen u_tick (
    .clk    (clk_Pulse),
    .rst    (rst_Pulse),
    .clear  (!in_pulse || !PL_launch),
    .enable (in_pulse),
    .mlt    (mlt_q),
    .tick   (tick)
  );

  always_ff @(posedge clk_Pulse) begin
    if (rst_Pulse) begin
      state       <= ST_IDLE;
      PL_out      <= 1'b0;
      End_Flg_PL  <= 1'b0;
      busy        <= 1'b0;
      unit_cnt    <= '0;
      len_q       <= '0;
      mlt_q       <= '0;
      launch_prev <= 1'b1;
    end else begin
      launch_prev <= PL_launch;
      End_Flg_PL  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_edge) begin
            len_q    <= pulse_len;
            mlt_q    <= pl_mlt;
            unit_cnt <= '0;
            busy     <= 1'b1;
            if (pulse_len != '0) begin
              state  <= ST_PULSE;
              PL_out <= 1'b1;
            end else begin
              state      <= ST_DONE;
              End_Flg_PL <= 1'b1;
            end
          end
        end
        ST_PULSE: begin
          if (!PL_launch) begin
            state    <= ST_IDLE;
            PL_out   <= 1'b0;
            busy     <= 1'b0;
            unit_cnt <= '0;
          end else if (tick) begin
            if (unit_nxt == len_q) begin
              state      <= ST_DONE;
              PL_out     <= 1'b0;
              End_Flg_PL <= 1'b1;
              unit_cnt   <= '0;
            end else begin
              unit_cnt <= unit_nxt;
            end
          end
        end
        ST_DONE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!PL_launch) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          PL_out   <= 1'b0;
          busy     <= 1'b0;
          unit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
